// File: rtl/instr_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : instr_issue_ctrl
// Purpose  : Buffers MIPS instruction words in a small FIFO and issues them
//            one at a time through an IDLE -> ISSUE -> WB sequencer. Decodes
//            register-file addresses and ALU controls from the held
//            instruction, raises RegWrite in WB for legal R-type writes,
//            flags illegal words with a one-cycle pulse and counts retired
//            legal instructions.
// Ports    : clk, rst           - clock, asynchronous active-high reset
//            in_valid/in_ready  - upstream instruction handshake
//            instr              - 32-bit instruction word
//            rd_addr1/rd_addr2  - RF read addresses (rs, rt)
//            wr_addr            - RF write address (rd)
//            shamt, funct       - ALU shift amount and operation select
//            RegWrite           - RF write enable (WB only)
//            busy               - FIFO non-empty or sequencer active
//            illegal            - pulse in WB of a discarded illegal word
//            retired_cnt        - legal instructions completed (wraps)
// Revision : 1.0 - initial release
// ============================================================================
module instr_issue_ctrl #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    output logic [4:0]       rd_addr1,
    output logic [4:0]       rd_addr2,
    output logic [4:0]       wr_addr,
    output logic [4:0]       shamt,
    output logic [3:0]       funct,
    output logic             RegWrite,
    output logic             busy,
    output logic             illegal,
    output logic [CNT_W-1:0] retired_cnt
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WB    = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [31:0]      mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    state_t           state_q;
    logic [31:0]      ir_q;
    logic             regwrite_q;
    logic             illegal_q;

    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             ir_legal;

    // Full/empty come from the registered occupancy only, so in_ready never
    // depends on a pop happening in the same cycle.
    assign full  = (occ_q == OCC_W'(DEPTH));
    assign empty = (occ_q == '0);
    assign push  = in_valid && !full;
    // The sequencer can take a new word only when it is idle or finishing WB.
    assign pop   = !empty && ((state_q == S_IDLE) || (state_q == S_WB));

    // R-type opcode with an arithmetic/logic funct (bit 5 set) or a
    // shift funct (funct[5:3] == 000); everything else is discarded.
    assign ir_legal = (ir_q[31:26] == 6'b000000) &&
                      (ir_q[5] || (ir_q[5:3] == 3'b000));

    // ------------------------------------------------------------------
    // FIFO / counter next-state
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        cnt_d    = cnt_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({push, pop})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase

        // Retire at the end of WB; wraps naturally at 2^CNT_W.
        if ((state_q == S_WB) && ir_legal) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= instr;
        end
    end

    // ------------------------------------------------------------------
    // Issue sequencer with registered RegWrite / illegal
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            ir_q       <= '0;
            regwrite_q <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    regwrite_q <= 1'b0;
                    illegal_q  <= 1'b0;
                    if (pop) begin
                        ir_q    <= mem_q[rd_ptr_q];
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // Outputs for WB are set up on the way in, so they are
                    // valid for exactly the WB cycle.
                    regwrite_q <= ir_legal && (ir_q[15:11] != 5'd0);
                    illegal_q  <= !ir_legal;
                    state_q    <= S_WB;
                end
                S_WB: begin
                    regwrite_q <= 1'b0;
                    illegal_q  <= 1'b0;
                    if (pop) begin
                        ir_q    <= mem_q[rd_ptr_q];
                        state_q <= S_ISSUE;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    regwrite_q <= 1'b0;
                    illegal_q  <= 1'b0;
                    state_q    <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // Decode straight from the instruction register: it only changes on a
    // pop, so fields hold through ISSUE, WB and any following IDLE.
    assign rd_addr1    = ir_q[25:21];
    assign rd_addr2    = ir_q[20:16];
    assign wr_addr     = ir_q[15:11];
    assign shamt       = ir_q[10:6];
    assign funct       = ir_q[3:0];
    assign RegWrite    = regwrite_q;
    assign illegal     = illegal_q;
    assign retired_cnt = cnt_q;
    assign in_ready    = !full;
    assign busy        = !empty || (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_instr_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_issue_ctrl
// Purpose  : Scoreboard bench for instr_issue_ctrl. Directed instruction
//            words with hand-decoded fields are queued on acceptance; a
//            negedge monitor pops and compares on each WB event.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] instr = '0;
    logic        in_ready, RegWrite, busy, illegal;
    logic [4:0]  rd_addr1, rd_addr2, wr_addr, shamt;
    logic [3:0]  funct;
    logic [15:0] retired_cnt;

    logic        in_valid2 = 1'b0;
    logic [31:0] instr2 = '0;
    logic        in_ready2, RegWrite2, busy2, illegal2;
    logic [4:0]  rd_addr1_2, rd_addr2_2, wr_addr2, shamt2;
    logic [3:0]  funct2;
    logic [1:0]  retired_cnt2;

    always #5 clk = ~clk;

    instr_issue_ctrl #(.DEPTH(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .wr_addr(wr_addr), .shamt(shamt), .funct(funct),
        .RegWrite(RegWrite), .busy(busy), .illegal(illegal),
        .retired_cnt(retired_cnt)
    );

    instr_issue_ctrl #(.DEPTH(4), .CNT_W(2)) dut_w (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
        .instr(instr2), .rd_addr1(rd_addr1_2), .rd_addr2(rd_addr2_2),
        .wr_addr(wr_addr2), .shamt(shamt2), .funct(funct2),
        .RegWrite(RegWrite2), .busy(busy2), .illegal(illegal2),
        .retired_cnt(retired_cnt2)
    );

    typedef struct {
        logic [31:0] word;
        logic        rw;
        logic        ill;
        logic        lg;
        logic [4:0]  rs, rt, rd, sh;
        logic [3:0]  fn;
    } vec_t;

    typedef struct {
        vec_t        v;
        logic [15:0] cnt;
    } exp_t;

    vec_t        V [9];
    exp_t        sbq [$];
    int          rw_cycles [$];
    int          checks = 0;
    int          errors = 0;
    int          cycle = 0;
    int          ill_pulses = 0;
    logic [15:0] mcnt = '0;
    logic        saw_full = 1'b0;

    localparam int ADD = 0, LW = 1, ADD0 = 2, SLL = 3, SUB = 4,
                   AND = 5, OR = 6, JR = 7, SRA = 8;

    function automatic vec_t mk(input logic [31:0] w, input logic rw,
                                input logic ill, input logic lg,
                                input int rs, input int rt, input int rd,
                                input int sh, input int fn);
        vec_t v;
        v.word = w; v.rw = rw; v.ill = ill; v.lg = lg;
        v.rs = 5'(rs); v.rt = 5'(rt); v.rd = 5'(rd); v.sh = 5'(sh);
        v.fn = 4'(fn);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    always @(posedge clk) cycle++;

    // ------------------------------------------------------------------
    // Monitor: a WB shows up as RegWrite/illegal, or (for legal rd==0)
    // only as a counter step; the counter is checked one cycle after.
    // ------------------------------------------------------------------
    logic        pending = 1'b0;
    exp_t        pend_e;
    logic [15:0] prev_cnt = '0;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            pending  = 1'b0;
            prev_cnt = retired_cnt;
        end else begin
            if (pending) begin
                chk("cnt_after_wb", 32'(retired_cnt), 32'(pend_e.cnt));
                pending  = 1'b0;
                prev_cnt = retired_cnt;
            end else if (retired_cnt != prev_cnt) begin
                if (sbq.size() == 0) begin
                    fail_now("unexpected_retire");
                end else begin
                    e = sbq.pop_front();
                    // A silent retire is only right for a legal rd==0 word.
                    chk("silent_retire_rw", 32'(0), 32'(e.v.rw));
                    chk("cnt_silent", 32'(retired_cnt), 32'(e.cnt));
                end
                prev_cnt = retired_cnt;
            end
            if (RegWrite || illegal) begin
                if (illegal) ill_pulses++;
                if (RegWrite) rw_cycles.push_back(cycle);
                if (sbq.size() == 0) begin
                    fail_now("unexpected_wb_pulse");
                end else begin
                    e = sbq.pop_front();
                    chk("wb_RegWrite", 32'(RegWrite), 32'(e.v.rw));
                    chk("wb_illegal",  32'(illegal),  32'(e.v.ill));
                    chk("wb_rd_addr1", 32'(rd_addr1), 32'(e.v.rs));
                    chk("wb_rd_addr2", 32'(rd_addr2), 32'(e.v.rt));
                    chk("wb_wr_addr",  32'(wr_addr),  32'(e.v.rd));
                    chk("wb_shamt",    32'(shamt),    32'(e.v.sh));
                    chk("wb_funct",    32'(funct),    32'(e.v.fn));
                    pend_e  = e;
                    pending = 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic push(input int idx);
        int   t;
        exp_t e;
        t = 0;
        instr    = V[idx].word;
        in_valid = 1'b1;
        if (!in_ready) saw_full = 1'b1;
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            fail_now("push_timeout");
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        if (V[idx].lg) mcnt = mcnt + 16'd1;
        e.v   = V[idx];
        e.cnt = mcnt;
        sbq.push_back(e);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        @(negedge clk);
        while (busy && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (busy) fail_now("idle_timeout");
        @(negedge clk);
        @(negedge clk);
    endtask

    int exp_w [5] = '{1, 2, 3, 0, 1};

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // Hand-decoded vectors: word, RegWrite, illegal, legal, rs, rt, rd, shamt, funct[3:0]
        V[ADD]  = mk(32'h014B4820, 1, 0, 1, 10, 11,  9, 0, 0);
        V[LW]   = mk(32'h8C090000, 0, 1, 0,  0,  9,  0, 0, 0);
        V[ADD0] = mk(32'h00000020, 0, 0, 1,  0,  0,  0, 0, 0);
        V[SLL]  = mk(32'h000A4940, 1, 0, 1,  0, 10,  9, 5, 0);
        V[SUB]  = mk(32'h00221822, 1, 0, 1,  1,  2,  3, 0, 2);
        V[AND]  = mk(32'h00853024, 1, 0, 1,  4,  5,  6, 0, 4);
        V[OR]   = mk(32'h00E84025, 1, 0, 1,  7,  8,  8, 0, 5);
        V[JR]   = mk(32'h03E00008, 0, 1, 0, 31,  0,  0, 0, 8);
        V[SRA]  = mk(32'h00041083, 1, 0, 1,  0,  4,  2, 2, 3);

        // Reset state
        #1 rst = 1'b1;
        #1;
        chk("rst_in_ready",    32'(in_ready),    32'd1);
        chk("rst_busy",        32'(busy),        32'd0);
        chk("rst_RegWrite",    32'(RegWrite),    32'd0);
        chk("rst_illegal",     32'(illegal),     32'd0);
        chk("rst_retired_cnt", 32'(retired_cnt), 32'd0);
        chk("rst_rd_addr1",    32'(rd_addr1),    32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Single add with latency
        push(ADD);
        @(negedge clk);
        @(negedge clk);
        chk("lat_issue_rd_addr1", 32'(rd_addr1), 32'd10);
        chk("lat_issue_rd_addr2", 32'(rd_addr2), 32'd11);
        chk("lat_issue_RegWrite", 32'(RegWrite), 32'd0);
        @(negedge clk);
        chk("lat_wb_RegWrite", 32'(RegWrite), 32'd1);
        chk("lat_wb_wr_addr",  32'(wr_addr),  32'd9);
        chk("lat_wb_funct",    32'(funct),    32'd0);
        wait_idle();
        chk("add_retired_cnt", 32'(retired_cnt), 32'd1);

        // Illegal words and the $0 destination
        ill_pulses = 0;
        push(LW);
        wait_idle();
        chk("lw_illegal_pulses", 32'(ill_pulses),  32'd1);
        chk("lw_retired_cnt",    32'(retired_cnt), 32'd1);
        push(ADD0);
        wait_idle();
        chk("add0_retired_cnt",  32'(retired_cnt), 32'd2);
        push(JR);
        wait_idle();
        chk("jr_illegal_pulses", 32'(ill_pulses),  32'd2);
        chk("jr_retired_cnt",    32'(retired_cnt), 32'd2);

        // Shift; fields stay on the outputs once back in IDLE
        push(SLL);
        wait_idle();
        chk("sll_idle_shamt",    32'(shamt),       32'd5);
        chk("sll_idle_rd_addr2", 32'(rd_addr2),    32'd10);
        chk("sll_idle_wr_addr",  32'(wr_addr),     32'd9);
        chk("sll_retired_cnt",   32'(retired_cnt), 32'd3);

        // Back-pressure burst: pushes outrun the 1-per-2-cycle drain
        rw_cycles.delete();
        saw_full = 1'b0;
        push(ADD); push(SUB); push(AND); push(OR);
        push(SRA); push(SLL); push(ADD); push(SUB);
        wait_idle();
        chk("burst_saw_full",    32'(saw_full),         32'd1);
        chk("burst_pulse_count", 32'(rw_cycles.size()), 32'd8);
        for (int i = 1; i < rw_cycles.size(); i++) begin
            chk("burst_pulse_gap", 32'(rw_cycles[i] - rw_cycles[i-1]), 32'd2);
        end
        chk("burst_retired_cnt", 32'(retired_cnt), 32'd11);
        chk("burst_sb_drained",  32'(sbq.size()),  32'd0);

        // Reset during ISSUE with three words buffered
        push(ADD0); push(ADD0); push(ADD); push(SUB); push(AND); push(OR);
        @(negedge clk);
        chk("pre_rst_busy",     32'(busy),     32'd1);
        chk("pre_rst_rd_addr1", 32'(rd_addr1), 32'd10);
        chk("pre_rst_RegWrite", 32'(RegWrite), 32'd0);
        #1 rst = 1'b1;
        #1;
        chk("midrst_busy",        32'(busy),        32'd0);
        chk("midrst_in_ready",    32'(in_ready),    32'd1);
        chk("midrst_retired_cnt", 32'(retired_cnt), 32'd0);
        chk("midrst_RegWrite",    32'(RegWrite),    32'd0);
        sbq.delete();
        rw_cycles.delete();
        mcnt = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        chk("postrst_pulses",      32'(rw_cycles.size()), 32'd0);
        chk("postrst_busy",        32'(busy),             32'd0);
        chk("postrst_retired_cnt", 32'(retired_cnt),      32'd0);

        // Resume after reset
        push(OR);
        wait_idle();
        chk("resume_retired_cnt", 32'(retired_cnt), 32'd1);
        chk("final_sb_drained",   32'(sbq.size()),  32'd0);

        // Counter wrap on the CNT_W=2 instance
        for (int k = 0; k < 5; k++) begin
            int t;
            t = 0;
            instr2    = V[ADD].word;
            in_valid2 = 1'b1;
            @(posedge clk);
            #1 in_valid2 = 1'b0;
            @(negedge clk);
            while (busy2 && t < 50) begin
                @(negedge clk);
                t++;
            end
            if (busy2) fail_now("wrap_idle_timeout");
            chk("wrap_retired_cnt", 32'(retired_cnt2), 32'(exp_w[k]));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
